gj_axis_uart_rx_pkt_fifo: RTL and testbench

- Store-and-forward packet buffer directly downstream of the UART receive AXI-stream output (rx_tvalid/rx_tdata/rx_tlast).
- The UART RX side has no backpressure, so this block absorbs bytes at line rate.
- Only complete, good frames are released to the consumer on a standard AXI-stream master with tready.
- Frames that overflow the buffer, or that carry a byte error, are discarded whole and counted.

---
 rtl/gj_axis_uart_rx_pkt_fifo.sv | 164 ++++++++++++++++
 tb/tb_gj_axis_uart_rx_pkt_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gj_axis_uart_rx_pkt_fifo.sv
// Store-and-forward frame buffer behind UART RX; releases only good frames and drops overflowing or errored ones whole.
// Latency: m_tvalid two clocks after commit. Input has no backpressure; output is AXI-stream and honours m_tready.
module gj_axis_uart_rx_pkt_fifo #(
    parameter int DEPTH_LOG2 = 10,
    parameter bit DROP_ERR   = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_tvalid,
    input  logic [7:0]            s_tdata,
    input  logic                  s_tlast,
    input  logic                  s_tuser,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [7:0]            m_tdata,
    output logic                  m_tlast,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic [DEPTH_LOG2:0]   fill
);

    localparam int PW      = DEPTH_LOG2 + 1;
    localparam int DEPTH_N = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [8:0]    mem [0:DEPTH_N-1];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_commit;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_addr;
    logic          dropping;
    logic          bad;
    logic [8:0]    ram_q;
    logic          ram_vld;

    logic full;
    logic beat;
    logic ovf;
    logic wr_en;
    logic frame_end;
    logic err_drop;
    logic drop_frame;
    logic commit;
    logic out_ready;
    logic s1_ready;
    logic rd_en;
    logic pop;
    logic pop_last;

    // rd_ptr only moves on consumer handshake, so prefetched bytes still count as held
    assign fill       = wr_ptr - rd_ptr;
    assign full       = (fill == DEPTH);
    assign beat       = s_tvalid & ~flush;
    assign ovf        = beat & full;
    assign wr_en      = beat & ~dropping & ~full;
    assign frame_end  = beat & s_tlast;
    assign err_drop   = DROP_ERR & (bad | s_tuser);
    assign drop_frame = frame_end & (dropping | ovf | err_drop);
    assign commit     = frame_end & ~drop_frame;

    assign out_ready  = ~m_tvalid | m_tready;
    assign s1_ready   = ~ram_vld | out_ready;
    assign rd_en      = ~flush & (rd_addr != wr_commit) & s1_ready;
    assign pop        = m_tvalid & m_tready;
    assign pop_last   = pop & m_tlast;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_tlast, s_tdata};
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            wr_commit <= '0;
            dropping  <= 1'b0;
            bad       <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            wr_commit <= '0;
            dropping  <= 1'b0;
            bad       <= 1'b0;
        end else if (drop_frame) begin
            wr_ptr    <= wr_commit;
            dropping  <= 1'b0;
            bad       <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (commit) begin
                wr_commit <= wr_ptr + 1'b1;
                bad       <= 1'b0;
            end else if (beat) begin
                bad <= bad | s_tuser;
                if (ovf) begin
                    dropping <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_frame && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (flush) begin
            pkt_cnt <= '0;
        end else if (commit && !pop_last) begin
            pkt_cnt <= pkt_cnt + 1'b1;
        end else if (!commit && pop_last) begin
            pkt_cnt <= pkt_cnt - 1'b1;
        end
    end

    // Two-stage read: RAM output register, then the AXI output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            rd_addr  <= '0;
            ram_vld  <= 1'b0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else if (flush) begin
            rd_ptr   <= '0;
            rd_addr  <= '0;
            ram_vld  <= 1'b0;
            m_tvalid <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_addr <= rd_addr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (rd_en) begin
                ram_vld <= 1'b1;
            end else if (out_ready) begin
                ram_vld <= 1'b0;
            end
            if (out_ready) begin
                m_tvalid <= ram_vld;
                if (ram_vld) begin
                    {m_tlast, m_tdata} <= ram_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_gj_axis_uart_rx_pkt_fifo.sv
// Directed bench: u_dut is a 16-entry buffer that drops errored frames, u_keep the same buffer keeping them.
module tb_gj_axis_uart_rx_pkt_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        s_tvalid;
    logic [7:0]  s_tdata;
    logic        s_tlast;
    logic        s_tuser;
    logic        m_tready;

    logic        m_tvalid, k_m_tvalid;
    logic [7:0]  m_tdata, k_m_tdata;
    logic        m_tlast, k_m_tlast;
    logic [15:0] pkt_cnt, k_pkt_cnt;
    logic [15:0] drop_cnt, k_drop_cnt;
    logic [4:0]  fill, k_fill;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gj_axis_uart_rx_pkt_fifo #(.DEPTH_LOG2(4), .DROP_ERR(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .fill(fill)
    );

    gj_axis_uart_rx_pkt_fifo #(.DEPTH_LOG2(4), .DROP_ERR(1'b0), .CNT_W(16)) u_keep (
        .clk(clk), .rst(rst), .flush(flush),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tvalid(k_m_tvalid), .m_tready(m_tready), .m_tdata(k_m_tdata), .m_tlast(k_m_tlast),
        .pkt_cnt(k_pkt_cnt), .drop_cnt(k_drop_cnt), .fill(k_fill)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic u);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        s_tuser  = u;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        int n = 0;
        while (!m_tvalid && n < 10) begin
            tick();
            n++;
        end
        check({tag, " wait vld"}, m_tvalid, 1);
    endtask

    task automatic expect_beat(input string tag, input logic [7:0] d, input logic l);
        check({tag, " vld"}, m_tvalid, 1);
        check({tag, " dat"}, m_tdata, d);
        check({tag, " lst"}, m_tlast, l);
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; m_tready = 1'b0;
        s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; s_tuser = 1'b0;
        #2;
        check("rst vld", m_tvalid, 0);
        check("rst dat", m_tdata, 0);
        check("rst lst", m_tlast, 0);
        check("rst pkt", pkt_cnt, 0);
        check("rst drop", drop_cnt, 0);
        check("rst fill", fill, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 10-byte frame, exact latency and back-to-back readout
        m_tready = 1'b1;
        for (int i = 0; i < 10; i++) send(8'h0A + 8'(i), i == 9, 1'b0);
        check("t1 pkt", pkt_cnt, 1);
        check("t1 fill", fill, 10);
        check("t1 vld E0", m_tvalid, 0);
        tick();
        check("t1 vld E1", m_tvalid, 0);
        tick();
        for (int i = 0; i < 10; i++) expect_beat($sformatf("t1 b%0d", i), 8'h0A + 8'(i), i == 9);
        check("t1 vld end", m_tvalid, 0);
        check("t1 pkt end", pkt_cnt, 0);
        check("t1 fill end", fill, 0);

        // 3-byte and 1-byte frames under stall
        m_tready = 1'b0;
        send(8'h21, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h23, 1'b1, 1'b0);
        send(8'h31, 1'b1, 1'b0);
        check("t2 pkt", pkt_cnt, 2);
        check("t2 fill", fill, 4);
        tick(); tick(); tick();
        check("t2 hold vld", m_tvalid, 1);
        check("t2 hold dat", m_tdata, 8'h21);
        m_tready = 1'b1;
        expect_beat("t2 b0", 8'h21, 1'b0);
        expect_beat("t2 b1", 8'h22, 1'b0);
        expect_beat("t2 b2", 8'h23, 1'b1);
        expect_beat("t2 b3", 8'h31, 1'b1);
        check("t2 vld end", m_tvalid, 0);
        check("t2 pkt end", pkt_cnt, 0);
        check("t2 fill end", fill, 0);

        // 20-byte frame exceeds depth; 16-byte frame fits exactly
        for (int i = 0; i < 20; i++) send(8'h40 + 8'(i), i == 19, 1'b0);
        check("t3 drop", drop_cnt, 1);
        check("t3 fill", fill, 0);
        check("t3 pkt", pkt_cnt, 0);
        tick(); tick(); tick();
        check("t3 no vld", m_tvalid, 0);
        for (int i = 0; i < 16; i++) send(8'h60 + 8'(i), i == 15, 1'b0);
        check("t3 pkt16", pkt_cnt, 1);
        check("t3 fill16", fill, 16);
        wait_vld("t3");
        for (int i = 0; i < 16; i++) expect_beat($sformatf("t3 b%0d", i), 8'h60 + 8'(i), i == 15);
        check("t3 fill end", fill, 0);
        check("t3 pkt end", pkt_cnt, 0);

        // 12 committed and stalled, then a 6-byte frame overflows on byte 5
        m_tready = 1'b0;
        for (int i = 0; i < 12; i++) send(8'h80 + 8'(i), i == 11, 1'b0);
        check("t4 fill12", fill, 12);
        for (int i = 0; i < 6; i++) begin
            send(8'hA0 + 8'(i), i == 5, 1'b0);
            if (i == 3) check("t4 full", fill, 16);
        end
        check("t4 drop", drop_cnt, 2);
        check("t4 fill", fill, 12);
        check("t4 pkt", pkt_cnt, 1);
        m_tready = 1'b1;
        for (int i = 0; i < 12; i++) expect_beat($sformatf("t4 b%0d", i), 8'h80 + 8'(i), i == 11);
        check("t4 vld end", m_tvalid, 0);
        check("t4 fill end", fill, 0);

        // errored byte: dropped by u_dut, delivered by u_keep
        for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i), i == 4, i == 2);
        check("t5 drop", drop_cnt, 3);
        check("t5 fill", fill, 0);
        check("t5 pkt", pkt_cnt, 0);
        check("t5k pkt", k_pkt_cnt, 1);
        check("t5k fill", k_fill, 5);
        check("t5k drop", k_drop_cnt, 2);
        begin
            int n = 0;
            while (!k_m_tvalid && n < 10) begin tick(); n++; end
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5k b%0d vld", i), k_m_tvalid, 1);
            check($sformatf("t5k b%0d dat", i), k_m_tdata, 8'hC0 + 8'(i));
            check($sformatf("t5k b%0d lst", i), k_m_tlast, i == 4);
            check($sformatf("t5 b%0d no vld", i), m_tvalid, 0);
            tick();
        end
        check("t5k fill end", k_fill, 0);

        // async reset mid-readout and mid-frame
        m_tready = 1'b0;
        send(8'hD0, 1'b0, 1'b0);
        send(8'hD1, 1'b0, 1'b0);
        send(8'hD2, 1'b1, 1'b0);
        send(8'hD8, 1'b0, 1'b0);
        send(8'hD9, 1'b0, 1'b0);
        tick(); tick();
        check("t6 pre vld", m_tvalid, 1);
        rst = 1'b1;
        #1;
        check("t6 rst vld", m_tvalid, 0);
        check("t6 rst dat", m_tdata, 0);
        check("t6 rst lst", m_tlast, 0);
        check("t6 rst pkt", pkt_cnt, 0);
        check("t6 rst drop", drop_cnt, 0);
        check("t6 rst fill", fill, 0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check("t6 post vld", m_tvalid, 0);
        check("t6 post fill", fill, 0);

        // flush mid-readout keeps drop_cnt and discards the flush-cycle beat
        m_tready = 1'b1;
        send(8'h11, 1'b0, 1'b1);
        send(8'h12, 1'b1, 1'b0);
        check("t7 drop", drop_cnt, 1);
        for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i), i == 3, 1'b0);
        wait_vld("t7");
        expect_beat("t7 b0", 8'hE0, 1'b0);
        expect_beat("t7 b1", 8'hE1, 1'b0);
        check("t7 pkt pre", pkt_cnt, 1);
        flush = 1'b1;
        send(8'h55, 1'b1, 1'b0);
        flush = 1'b0;
        check("t7 fl vld", m_tvalid, 0);
        check("t7 fl pkt", pkt_cnt, 0);
        check("t7 fl drop", drop_cnt, 1);
        check("t7 fl fill", fill, 0);
        tick(); tick(); tick();
        check("t7 fl quiet", m_tvalid, 0);
        send(8'hF0, 1'b0, 1'b0);
        send(8'hF1, 1'b1, 1'b0);
        wait_vld("t7 post");
        expect_beat("t7 p0", 8'hF0, 1'b0);
        expect_beat("t7 p1", 8'hF1, 1'b1);
        check("t7 end pkt", pkt_cnt, 0);
        check("t7 end fill", fill, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
